// File: rtl/dpu_pkg.sv
// Shared types and encoding constants for the DPU instruction sequencer.
package dpu_pkg;

  localparam int unsigned PC_W_DEF = 8;
  localparam int unsigned IW       = 16;
  localparam int unsigned TGT_W    = 8;

  // Instruction field positions (LSB of each field)
  localparam int unsigned BIT_CLASS = 15;
  localparam int unsigned CTL_LSB   = 13;
  localparam int unsigned N_LSB     = 12;
  localparam int unsigned MASK_LSB  = 9;
  localparam int unsigned A_LSB     = 8;
  localparam int unsigned B_LSB     = 4;
  localparam int unsigned R_LSB     = 0;
  localparam int unsigned TGT_LSB   = 0;

  localparam logic [1:0] CTL_BCC  = 2'b00;
  localparam logic [1:0] CTL_JMP  = 2'b01;
  localparam logic [1:0] CTL_HALT = 2'b10;
  localparam logic [1:0] CTL_KSTB = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_CCCAP,
    ST_KSTB
  } state_t;

  typedef struct packed {
    logic             is_alu;
    logic [1:0]       ctl;
    logic [2:0]       n;
    logic [3:0]       a;
    logic [3:0]       b;
    logic [3:0]       r;
    logic [3:0]       mask;
    logic [TGT_W-1:0] target;
  } instr_t;

endpackage

// File: rtl/dpu_sequencer_if.sv
// Sequencer-to-memory/DPU bus: master is the sequencer, slave is imem + DPU.
interface dpu_sequencer_if
  import dpu_pkg::*;
#(
  parameter int unsigned PC_W = PC_W_DEF
) ();

  logic            imem_rd;
  logic [PC_W-1:0] imem_addr;
  logic [IW-1:0]   imem_data;
  logic [3:0]      abus;
  logic [3:0]      bbus;
  logic [3:0]      rbus;
  logic [2:0]      n;
  logic            alu_issue;
  logic [3:0]      cc;
  logic            k_strobe;

  modport master (
    output imem_rd, imem_addr, abus, bbus, rbus, n, alu_issue, k_strobe,
    input  imem_data, cc
  );

  modport slave (
    input  imem_rd, imem_addr, abus, bbus, rbus, n, alu_issue, k_strobe,
    output imem_data, cc
  );

endinterface

// File: rtl/dpu_instr_decode.sv
// Combinational field extractor for a 16-bit microinstruction.
module dpu_instr_decode
  import dpu_pkg::*;
(
  input  logic [IW-1:0] instr_i,
  output instr_t        fields_o
);

  always_comb begin
    fields_o.is_alu = ~instr_i[BIT_CLASS];
    fields_o.ctl    = instr_i[CTL_LSB  +: 2];
    fields_o.n      = instr_i[N_LSB    +: 3];
    fields_o.a      = instr_i[A_LSB    +: 4];
    fields_o.b      = instr_i[B_LSB    +: 4];
    fields_o.r      = instr_i[R_LSB    +: 4];
    fields_o.mask   = instr_i[MASK_LSB +: 4];
    fields_o.target = instr_i[TGT_LSB  +: TGT_W];
  end

endmodule

// File: rtl/dpu_sequencer.sv
// Microinstruction sequencer: fetch/decode/issue ALU ops to the DPU, branch on cc.
module dpu_sequencer
  import dpu_pkg::*;
#(
  parameter int unsigned PC_W = PC_W_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [PC_W-1:0] start_addr,
  output logic            busy,
  output logic            done,
  dpu_sequencer_if.master bus
);

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [IW-1:0]   ir_q, ir_d;
  logic [3:0]      cc_q, cc_d;
  logic [3:0]      abus_q, abus_d, bbus_q, bbus_d, rbus_q, rbus_d;
  logic [2:0]      n_q, n_d;
  logic            busy_q, busy_d, done_q, done_d;
  logic            imem_rd_q, imem_rd_d, alu_issue_q, alu_issue_d, k_strobe_q, k_strobe_d;
  logic [PC_W-1:0] imem_addr_q, imem_addr_d;

  instr_t          fld;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] br_pc;
  logic            taken;

  // Decode the word being latched so DECODE can act in the same cycle
  dpu_instr_decode u_decode (
    .instr_i  (ir_d),
    .fields_o (fld)
  );

  assign pc_inc = pc_q + PC_W'(1);
  assign taken  = (fld.ctl == CTL_JMP) || ((cc_q & fld.mask) != 4'd0);
  assign br_pc  = taken ? PC_W'(fld.target) : pc_inc;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    cc_d        = cc_q;
    abus_d      = abus_q;
    bbus_d      = bbus_q;
    rbus_d      = rbus_q;
    n_d         = n_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    imem_rd_d   = 1'b0;
    imem_addr_d = imem_addr_q;
    alu_issue_d = 1'b0;
    k_strobe_d  = 1'b0;

    // Strobes are set on entry to their state so they are registered outputs
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          pc_d        = start_addr;
          imem_rd_d   = 1'b1;
          imem_addr_d = start_addr;
          busy_d      = 1'b1;
          state_d     = ST_FETCH;
        end
      end
      ST_FETCH: state_d = ST_DECODE;
      ST_DECODE: begin
        ir_d = bus.imem_data;
        if (fld.is_alu) begin
          abus_d      = fld.a;
          bbus_d      = fld.b;
          rbus_d      = fld.r;
          n_d         = fld.n;
          alu_issue_d = 1'b1;
          state_d     = ST_EXEC;
        end else begin
          unique case (fld.ctl)
            CTL_BCC, CTL_JMP: begin
              pc_d        = br_pc;
              imem_rd_d   = 1'b1;
              imem_addr_d = br_pc;
              state_d     = ST_FETCH;
            end
            CTL_KSTB: begin
              pc_d       = pc_inc;
              k_strobe_d = 1'b1;
              state_d    = ST_KSTB;
            end
            default: begin
              done_d  = 1'b1;
              busy_d  = 1'b0;
              state_d = ST_IDLE;
            end
          endcase
        end
      end
      ST_EXEC: state_d = ST_CCCAP;
      ST_CCCAP: begin
        cc_d        = bus.cc;
        pc_d        = pc_inc;
        imem_rd_d   = 1'b1;
        imem_addr_d = pc_inc;
        state_d     = ST_FETCH;
      end
      ST_KSTB: begin
        imem_rd_d   = 1'b1;
        imem_addr_d = pc_q;
        state_d     = ST_FETCH;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      pc_q        <= '0;
      ir_q        <= '0;
      cc_q        <= '0;
      abus_q      <= '0;
      bbus_q      <= '0;
      rbus_q      <= '0;
      n_q         <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      imem_rd_q   <= 1'b0;
      imem_addr_q <= '0;
      alu_issue_q <= 1'b0;
      k_strobe_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      cc_q        <= cc_d;
      abus_q      <= abus_d;
      bbus_q      <= bbus_d;
      rbus_q      <= rbus_d;
      n_q         <= n_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      imem_rd_q   <= imem_rd_d;
      imem_addr_q <= imem_addr_d;
      alu_issue_q <= alu_issue_d;
      k_strobe_q  <= k_strobe_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign bus.imem_rd   = imem_rd_q;
  assign bus.imem_addr = imem_addr_q;
  assign bus.abus      = abus_q;
  assign bus.bbus      = bbus_q;
  assign bus.rbus      = rbus_q;
  assign bus.n         = n_q;
  assign bus.alu_issue = alu_issue_q;
  assign bus.k_strobe  = k_strobe_q;

endmodule

// File: tb/tb_dpu_sequencer.sv
// Directed bench for dpu_sequencer with a synchronous imem model and a fixed-cc DPU.
module tb_dpu_sequencer;
  import dpu_pkg::*;

  localparam int unsigned PW = 8;
  localparam logic [15:0] I_HALT = 16'hC000;
  localparam logic [15:0] I_KSTB = 16'hE000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [PW-1:0] start_addr = '0;
  logic          busy, done;
  logic [15:0]   rdata = '0;
  logic [3:0]    cc_drv = '0;
  logic [15:0]   imem [256];

  dpu_sequencer_if #(.PC_W(PW)) bus ();

  dpu_sequencer #(.PC_W(PW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .start_addr (start_addr),
    .busy       (busy),
    .done       (done),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (bus.imem_rd) rdata <= imem[bus.imem_addr];
  assign bus.imem_data = rdata;
  assign bus.cc        = cc_drv;

  int            cyc = 0;
  int            alu_cnt = 0, k_cnt = 0, k_cyc = 0;
  logic [3:0]    la = '0, lb = '0, lr = '0;
  logic [2:0]    ln = '0;
  logic [PW-1:0] fq[$];
  int            fc[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.alu_issue) begin
      alu_cnt++;
      la = bus.abus; lb = bus.bbus; lr = bus.rbus; ln = bus.n;
    end
    if (bus.k_strobe) begin
      k_cnt++;
      k_cyc = cyc;
    end
    if (bus.imem_rd) begin
      fq.push_back(bus.imem_addr);
      fc.push_back(cyc);
    end
  end

  int errs = 0, checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"},  32'(busy), 0);
    chk({tag, "_done"},  32'(done), 0);
    chk({tag, "_rd"},    32'(bus.imem_rd), 0);
    chk({tag, "_addr"},  32'(bus.imem_addr), 0);
    chk({tag, "_abus"},  32'(bus.abus), 0);
    chk({tag, "_bbus"},  32'(bus.bbus), 0);
    chk({tag, "_rbus"},  32'(bus.rbus), 0);
    chk({tag, "_n"},     32'(bus.n), 0);
    chk({tag, "_issue"}, 32'(bus.alu_issue), 0);
    chk({tag, "_kstb"},  32'(bus.k_strobe), 0);
  endtask

  // Start at addr, optionally pulse start again while busy, return cycles to done
  task automatic run(input logic [PW-1:0] a, input bit glitch, output int lat);
    fq.delete();
    fc.delete();
    start = 1'b1;
    start_addr = a;
    step();
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 1);
    lat = 0;
    while (!done && lat < 200) begin
      if (glitch && lat == 1) begin
        start = 1'b1;
        start_addr = 8'h50;
      end else begin
        start = 1'b0;
      end
      step();
      lat++;
    end
    start = 1'b0;
    chk("done_seen", 32'(done), 1);
    chk("busy_low_at_done", 32'(busy), 0);
    step();
    chk("done_one_cycle", 32'(done), 0);
  endtask

  int lat, n, a0, k0;

  initial begin
    for (int i = 0; i < 256; i++) imem[i] = I_HALT;
    imem[8'h10] = 16'h2129; imem[8'h11] = I_HALT;
    imem[8'h20] = 16'h1345; imem[8'h21] = 16'h8840; imem[8'h40] = I_HALT;
    imem[8'h30] = 16'h1345; imem[8'h31] = 16'h8640; imem[8'h32] = I_HALT;
    imem[8'h50] = I_KSTB;   imem[8'h51] = I_HALT;
    imem[8'h60] = 16'h5371; imem[8'h61] = I_HALT;
    imem[8'hFF] = 16'hA000; imem[8'h00] = I_HALT;

    step();
    step();
    chk_reset_outputs("por");
    rst_n = 1'b1;
    step();

    // Reset during EXEC of an ALU op
    start = 1'b1; start_addr = 8'h60;
    step();
    start = 1'b0;
    n = 0;
    while (!bus.alu_issue && n < 20) begin step(); n++; end
    chk("exec_abus", 32'(bus.abus), 3);
    a0 = alu_cnt;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    step();
    rst_n = 1'b1;
    step();
    chk("midrst_no_issue", 32'(alu_cnt - a0), 0);

    // ALU then HALT
    a0 = alu_cnt;
    run(8'h10, 1'b0, lat);
    chk("alu_lat", 32'(lat), 6);
    chk("alu_issue_cnt", 32'(alu_cnt - a0), 1);
    chk("alu_a", 32'(la), 1);
    chk("alu_b", 32'(lb), 2);
    chk("alu_r", 32'(lr), 9);
    chk("alu_n", 32'(ln), 2);
    chk("abus_hold", 32'(bus.abus), 1);
    chk("busy_after", 32'(busy), 0);

    // BCC taken on captured cc
    cc_drv = 4'b0100;
    run(8'h20, 1'b0, lat);
    chk("bcc_t_lat", 32'(lat), 8);
    chk("bcc_t_nfetch", 32'(fq.size()), 3);
    if (fq.size() > 2) chk("bcc_t_target", 32'(fq[2]), 32'h40);

    // BCC not taken
    run(8'h30, 1'b0, lat);
    chk("bcc_nt_nfetch", 32'(fq.size()), 3);
    if (fq.size() > 2) chk("bcc_nt_next", 32'(fq[2]), 32'h32);
    cc_drv = 4'b0000;

    // JMP at 0xFF to 0x00
    run(8'hFF, 1'b0, lat);
    chk("jmp_lat", 32'(lat), 4);
    if (fq.size() > 1) chk("jmp_wrap", 32'(fq[1]), 0);
    else chk("jmp_nfetch", 32'(fq.size()), 2);

    // Sequential ALU at 0xFF wraps to 0x00
    imem[8'hFF] = 16'h2129;
    run(8'hFF, 1'b0, lat);
    chk("seq_lat", 32'(lat), 6);
    if (fq.size() > 1) chk("seq_wrap", 32'(fq[1]), 0);
    else chk("seq_nfetch", 32'(fq.size()), 2);

    // KSTB then HALT
    a0 = alu_cnt;
    k0 = k_cnt;
    run(8'h50, 1'b0, lat);
    chk("kstb_lat", 32'(lat), 5);
    chk("kstb_cnt", 32'(k_cnt - k0), 1);
    chk("kstb_no_issue", 32'(alu_cnt - a0), 0);
    if (fc.size() > 0) chk("kstb_delay", 32'(k_cyc - fc[0]), 2);

    // start while busy is ignored
    a0 = alu_cnt;
    k0 = k_cnt;
    run(8'h10, 1'b1, lat);
    chk("glitch_lat", 32'(lat), 6);
    chk("glitch_nfetch", 32'(fq.size()), 2);
    if (fq.size() > 1) chk("glitch_fetch1", 32'(fq[1]), 32'h11);
    chk("glitch_issue", 32'(alu_cnt - a0), 1);
    chk("glitch_no_kstb", 32'(k_cnt - k0), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/dpu_sequencer.md
# dpu_sequencer

Instruction sequencer that drives the DPU's operand/control side: fetches 16-bit microinstructions from a synchronous instruction memory, issues ALU operations on the DPU's `abus`/`bbus`/`rbus`/`n` inputs, captures the returned condition codes, and branches on them. It also strobes downstream consumers when the DPU's 24-bit Kbus colour word is ready. It is the initiator for the DPU register-file/ALU interface and sits between the host control logic and the DPU.

## Interface
Parameters:
- `PC_W`, 8, program-counter / imem address width (256 words)
- `IW`, 16, instruction width (fixed by encoding; not tunable)

Ports:
- `clk` in 1 — single clock, all state on rising edge
- `rst_n` in 1 — asynchronous, active-low reset
- `start` in 1 — begin execution at `start_addr`; honoured only in IDLE
- `start_addr` in PC_W — entry address
- `busy` out 1 — high from the cycle after accepted `start` until `done`
- `done` out 1 — one-cycle pulse on HALT
- `imem_rd` out 1 — read enable
- `imem_addr` out PC_W — read address
- `imem_data` in 16 — read data, valid exactly 1 cycle after `imem_rd`
- `abus`, `bbus`, `rbus` out 4 — DPU register selects
- `n` out 3 — DPU ALU function
- `alu_issue` out 1 — one-cycle strobe: selects/function valid for a new op
- `cc` in 4 — DPU condition codes (combinational from DPU)
- `k_strobe` out 1 — one-cycle pulse: Kbus is valid to sample

## Operation
- Encoding, bit 15 = 0 (ALU): [14:12] n, [11:8] A, [7:4] B, [3:0] R.
- Bit 15 = 1 (control), [14:13]: 00 BCC — taken if `(cc_reg & instr[12:9]) != 0`, target [7:0]; 01 JMP to [7:0]; 10 HALT; 11 KSTB (pulse `k_strobe`). Unused bits ignored.
- `cc_reg` (4 b) holds last captured `cc`; reset 0; updated only by ALU ops.
- States: IDLE, FETCH, DECODE, EXEC, CCCAP, KSTB.
  - IDLE: on `start`, pc ← `start_addr`, → FETCH. Else stay.
  - FETCH: `imem_rd`=1, `imem_addr`=pc → DECODE.
  - DECODE: latch `imem_data` into `ir`. ALU: load abus/bbus/rbus/n registers → EXEC. BCC/JMP: pc ← taken ? target : pc+1 → FETCH. KSTB: pc ← pc+1 → KSTB. HALT: `done`=1 next cycle → IDLE.
  - EXEC: `alu_issue`=1 → CCCAP.
  - CCCAP: `cc_reg` ← `cc`; pc ← pc+1 → FETCH.
  - KSTB: `k_strobe`=1 → FETCH.
- PC arithmetic modulo 2^PC_W: pc 255 + 1 → 0; branch target is absolute.
- `start` while busy: ignored, no effect on pc.
- abus/bbus/rbus/n hold their last values outside EXEC (DPU sees stable selects).

## Timing
- Reset (async, any state): state IDLE; pc, ir, cc_reg, abus, bbus, rbus, n = 0; busy, done, imem_rd, alu_issue, k_strobe = 0; imem_addr = 0.
- All outputs registered; no combinational path input→output.
- Latency per instruction: ALU 4 cycles (FETCH, DECODE, EXEC, CCCAP); BCC/JMP 2; KSTB 3; HALT 2 (done pulse in cycle after DECODE, busy drops same cycle).
- `cc` sampled in CCCAP, i.e. one full cycle after `alu_issue`; DPU result must settle within one clock.
- BCC immediately after an ALU op sees that op's cc.
- `busy` high first cycle after accepted `start`; low in the cycle `done` is high.
- Reset asserted mid-instruction: no partial `alu_issue`/`k_strobe`; outputs go to reset values immediately.

## Structure
- Package `dpu_pkg`: state enum, class/control opcode constants (CTL_BCC, CTL_JMP, CTL_HALT, CTL_KSTB), instruction field bit positions, PC_W default.
- One sub-module natural: `dpu_instr_decode` — combinational field extractor from `ir` (is_alu, ctl, n, a, b, r, mask, target); FSM and registers stay in `dpu_sequencer`.

## Test plan
- Reset mid-EXEC (abus=3) -> all outputs 0 immediately, state IDLE, `start` next accepted normally.
- Program @0x10: ALU n=2,A=1,B=2,R=9; HALT; `start_addr`=0x10 -> `alu_issue` one cycle with abus=1,bbus=2,rbus=9,n=2; `done` pulse 6 cycles after start accepted; busy low thereafter.
- ALU op with DPU `cc`=0b0100, then BCC mask 0b0100 target 0x40 -> next fetch address 0x40; repeat with mask 0b0011 -> next fetch pc+1.
- JMP at 0xFF to 0x00 and sequential ALU at 0xFF -> pc wraps to 0x00 in both cases.
- KSTB then HALT -> `k_strobe` exactly one cycle, 2 cycles after its fetch; no `alu_issue`.
- `start` pulsed while busy with different `start_addr` -> ignored; program completes from original address.
